// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CONV = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_CONV = ST_CONV,
      S_DONE = ST_DONE
   } state_e;

   // Bits needed for 10^digits - 1. 10^d is never a power of two, so
   // ceil(log2(10^d)) = floor(d*log2(10)) + 1; log2(10) is scaled by 1e12.
   function automatic int bcd_min_bin_w(input int digits);
      longint unsigned scaled;
      scaled = 64'(digits) * 64'd3321928094887;
      return int'(scaled / 64'd1000000000000) + 1;
   endfunction

endpackage

// File: rtl/bcd_mac10.sv
// One Horner step of decimal conversion: acc*10 + d using shift-add, plus a
// flag for a nibble that is not a legal BCD digit.
module bcd_mac10
   import bcd_pkg::*;
#(
   parameter int BIN_W = 14
) (
   input  logic [BIN_W-1:0] acc,
   input  logic [3:0]       d,
   output logic [BIN_W-1:0] acc_next,
   output logic             digit_bad
);

   always_comb begin
      acc_next  = (acc << 3) + (acc << 1) + BIN_W'(d);
      digit_bad = (d > BCD_MAX_DIGIT);
   end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential multi-digit BCD-to-binary converter, one digit per clock, MSD
// first, with valid/ready handshakes on both the input and the result side.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | in_ready high, waiting for a word
// S_CONV | folding one digit per cycle into acc, cnt counts down to 0
// S_DONE | result presented, held until out_ready
module bcd_to_binary_seq
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   in_bcd,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BIN_W-1:0]      out_bin,
   output logic                  out_err
);

   localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   if (DIGITS < 1) begin : g_bad_digits
      $error("bcd_to_binary_seq: DIGITS must be at least 1");
   end
   if (BIN_W < bcd_min_bin_w(DIGITS)) begin : g_bad_width
      $error("bcd_to_binary_seq: BIN_W too small to hold 10^DIGITS-1");
   end

   state_e                state_q,     state_d;
   logic [BIN_W-1:0]      acc_q,       acc_d;
   logic [4*DIGITS-1:0]   sreg_q,      sreg_d;
   logic [CNT_W-1:0]      cnt_q,       cnt_d;
   logic                  err_q,       err_d;
   logic                  in_ready_q,  in_ready_d;
   logic                  out_valid_q, out_valid_d;
   logic [BIN_W-1:0]      out_bin_q,   out_bin_d;
   logic                  out_err_q,   out_err_d;

   logic [3:0]            digit;
   logic [BIN_W-1:0]      mac_acc;
   logic                  digit_bad;

   assign digit = sreg_q[4*DIGITS-1 -: 4];

   bcd_mac10 #(
      .BIN_W (BIN_W)
   ) u_mac10 (
      .acc       (acc_q),
      .d         (digit),
      .acc_next  (mac_acc),
      .digit_bad (digit_bad)
   );

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      sreg_d      = sreg_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_bin_d   = out_bin_q;
      out_err_d   = out_err_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               sreg_d     = in_bcd;
               acc_d      = '0;
               err_d      = 1'b0;
               cnt_d      = CNT_W'(DIGITS - 1);
               in_ready_d = 1'b0;
               state_d    = S_CONV;
            end
         end
         S_CONV: begin
            acc_d  = mac_acc;
            err_d  = err_q | digit_bad;
            sreg_d = sreg_q << 4;
            if (cnt_q == '0) begin
               // Result registers are loaded here so they are valid on the
               // same edge that raises out_valid.
               out_valid_d = 1'b1;
               out_err_d   = err_d;
               out_bin_d   = err_d ? '0 : mac_acc;
               state_d     = S_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d     = S_IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         sreg_q      <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_bin_q   <= '0;
         out_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         sreg_q      <= sreg_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_bin_q   <= out_bin_d;
         out_err_q   <= out_err_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_bin   = out_bin_q;
   assign out_err   = out_err_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: directed cases, randomized words
// against a positional-weight decimal model, backpressure, reset and streaming.
module tb_bcd_to_binary_seq;

   localparam int DIGITS = 4;
   localparam int BIN_W  = 14;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [15:0]       in_bcd;
   logic              out_valid;
   logic              out_ready;
   logic [BIN_W-1:0]  out_bin;
   logic              out_err;

   logic              in_valid2;
   logic              in_ready2;
   logic [7:0]        in_bcd2;
   logic              out_valid2;
   logic              out_ready2;
   logic [6:0]        out_bin2;
   logic              out_err2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bcd    (in_bcd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bin   (out_bin),
      .out_err   (out_err)
   );

   bcd_to_binary_seq #(.DIGITS(2), .BIN_W(7)) dut2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid2),
      .in_ready  (in_ready2),
      .in_bcd    (in_bcd2),
      .out_valid (out_valid2),
      .out_ready (out_ready2),
      .out_bin   (out_bin2),
      .out_err   (out_err2)
   );

   // Value = sum of digit * 10^position; any nibble above 9 marks an error.
   function automatic void ref_model(input logic [31:0] bcd, input int nd,
                                     output int val, output bit err);
      int p;
      int nib;
      val = 0;
      err = 1'b0;
      p   = 1;
      for (int i = 0; i < nd; i++) begin
         nib = int'(bcd[4*i +: 4]);
         if (nib > 9) err = 1'b1;
         val += nib * p;
         p   *= 10;
      end
      if (err) val = 0;
   endfunction

   function automatic logic [15:0] rand_word();
      logic [15:0] w;
      for (int i = 0; i < 4; i++) begin
         if ($urandom_range(0, 7) == 0) w[4*i +: 4] = 4'($urandom_range(10, 15));
         else                           w[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      return w;
   endfunction

   task automatic send_word(input logic [15:0] bcd, output bit ok);
      int n;
      ok = 1'b0;
      n  = 0;
      @(negedge clk);
      in_bcd   = bcd;
      in_valid = 1'b1;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (in_ready) begin
         @(posedge clk);
         ok = 1'b1;
      end
      #1;
      in_valid = 1'b0;
      in_bcd   = 16'($urandom);
   endtask

   task automatic wait_out(output int lat, output bit to);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!out_valid && lat < 20);
      to = !out_valid;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_bin !== '0 || out_err !== 1'b0) begin
         bad++;
         $display("FAIL reset: in_ready=%b out_valid=%b out_bin=%0d out_err=%b, want 1 0 0 0",
                  in_ready, out_valid, out_bin, out_err);
      end
   endtask

   task automatic test_directed();
      logic [15:0]      words [4] = '{16'h1234, 16'h0000, 16'h9999, 16'h12A4};
      logic [BIN_W-1:0] exp_b [4] = '{14'd1234, 14'd0, 14'd9999, 14'd0};
      logic             exp_e [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      bit ok, to;
      int lat;
      for (int i = 0; i < 4; i++) begin
         send_word(words[i], ok);
         wait_out(lat, to);
         total++;
         if (!ok || to || lat != DIGITS) begin
            bad++;
            $display("FAIL directed_latency %h: accepted=%b timeout=%b latency=%0d, want %0d",
                     words[i], ok, to, lat, DIGITS);
         end
         total++;
         if (out_bin !== exp_b[i] || out_err !== exp_e[i]) begin
            bad++;
            $display("FAIL directed_value %h: out_bin=%0d out_err=%b, want %0d %b",
                     words[i], out_bin, out_err, exp_b[i], exp_e[i]);
         end
         consume();
         total++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL directed_release %h: out_valid=%b in_ready=%b, want 0 1",
                     words[i], out_valid, in_ready);
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] w;
      int          ev;
      bit          ee;
      bit          ok, to;
      int          lat;
      for (int i = 0; i < 24; i++) begin
         w = rand_word();
         ref_model({16'h0, w}, DIGITS, ev, ee);
         send_word(w, ok);
         wait_out(lat, to);
         total++;
         if (!ok || to || lat != DIGITS || out_bin !== BIN_W'(ev) || out_err !== ee) begin
            bad++;
            $display("FAIL random %h: ok=%b to=%b lat=%0d out_bin=%0d out_err=%b, want lat %0d bin %0d err %b",
                     w, ok, to, lat, out_bin, out_err, DIGITS, ev, ee);
         end
         consume();
      end
   endtask

   task automatic test_backpressure();
      bit ok, to;
      int lat;
      send_word(16'h0042, ok);
      wait_out(lat, to);
      total++;
      if (!ok || to) begin
         bad++;
         $display("FAIL bp_start: accepted=%b timeout=%b", ok, to);
      end
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1;
         in_bcd   = 16'h0777;
         total++;
         if (out_valid !== 1'b1 || out_bin !== 14'd42 || out_err !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold cycle %0d: out_valid=%b out_bin=%0d out_err=%b in_ready=%b, want 1 42 0 0",
                     c, out_valid, out_bin, out_err, in_ready);
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      consume();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid();
      bit ok, to;
      int lat;
      int seen;
      out_ready = 1'b1;
      send_word(16'h5678, ok);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      total++;
      if (!ok || in_ready !== 1'b1 || out_valid !== 1'b0 || out_bin !== '0 || out_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid: ok=%b in_ready=%b out_valid=%b out_bin=%0d out_err=%b, want 1 1 0 0 0",
                  ok, in_ready, out_valid, out_bin, out_err);
      end
      seen = 0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++;
         $display("FAIL reset_mid_ghost: out_valid high %0d cycles after reset, want 0", seen);
      end
      out_ready = 1'b0;
      send_word(16'h0007, ok);
      wait_out(lat, to);
      total++;
      if (!ok || to || out_bin !== 14'd7 || out_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_after: ok=%b to=%b out_bin=%0d out_err=%b, want 7 0",
                  ok, to, out_bin, out_err);
      end
      consume();
   endtask

   task automatic test_back_to_back();
      logic [15:0] words [4] = '{16'h0001, 16'h0010, 16'h0100, 16'h1000};
      int got [$];
      int acc_cyc [4];
      int cyc, idx, ev;
      bit ee;
      cyc = 0;
      idx = 0;
      out_ready = 1'b1;
      while (cyc < 80 && got.size() < 4) begin
         @(negedge clk);
         cyc++;
         if (out_valid) got.push_back(int'(out_bin));
         if (idx < 4) begin
            in_bcd   = words[idx];
            in_valid = 1'b1;
            if (in_ready) begin
               acc_cyc[idx] = cyc;
               idx++;
            end
         end else begin
            in_valid = 1'b0;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      total++;
      if (got.size() != 4 || idx != 4) begin
         bad++;
         $display("FAIL b2b_count: results=%0d accepts=%0d, want 4 4", got.size(), idx);
      end
      for (int i = 0; i < 4; i++) begin
         ref_model({16'h0, words[i]}, DIGITS, ev, ee);
         if (i < got.size()) begin
            total++;
            if (got[i] != ev) begin
               bad++;
               $display("FAIL b2b_value %0d: out_bin=%0d, want %0d", i, got[i], ev);
            end
         end
         if (i > 0 && i < idx) begin
            total++;
            if (acc_cyc[i] - acc_cyc[i-1] != DIGITS + 2) begin
               bad++;
               $display("FAIL b2b_spacing %0d: %0d cycles, want %0d",
                        i, acc_cyc[i] - acc_cyc[i-1], DIGITS + 2);
            end
         end
      end
   endtask

   task automatic test_digits2();
      logic [7:0] words [4];
      int ev, lat;
      bit ee;
      words[0] = 8'h99;
      words[1] = 8'h07;
      words[2] = 8'hA3;
      words[3] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      for (int i = 0; i < 4; i++) begin
         ref_model({24'h0, words[i]}, 2, ev, ee);
         @(negedge clk);
         total++;
         if (in_ready2 !== 1'b1) begin
            bad++;
            $display("FAIL d2_ready %h: in_ready=%b, want 1", words[i], in_ready2);
         end
         in_bcd2   = words[i];
         in_valid2 = 1'b1;
         @(posedge clk);
         #1;
         in_valid2 = 1'b0;
         lat = 0;
         do begin
            @(posedge clk);
            #1;
            lat++;
         end while (!out_valid2 && lat < 20);
         total++;
         if (!out_valid2 || lat != 2 || out_bin2 !== 7'(ev) || out_err2 !== ee) begin
            bad++;
            $display("FAIL d2_value %h: valid=%b lat=%0d out_bin=%0d out_err=%b, want lat 2 bin %0d err %b",
                     words[i], out_valid2, lat, out_bin2, out_err2, ev, ee);
         end
         out_ready2 = 1'b1;
         @(posedge clk);
         #1;
         out_ready2 = 1'b0;
      end
   endtask

   initial begin
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_bcd     = '0;
      out_ready  = 1'b0;
      in_valid2  = 1'b0;
      in_bcd2    = '0;
      out_ready2 = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_digits2();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/bcd_to_binary_seq.md
Name: bcd_to_binary_seq

Overview:
- Parametrised, multi-digit, sequential successor to the 4-bit combinational BCD-to-binary converter.
- Accepts a packed DIGITS-digit BCD word over a valid/ready handshake.
- Converts it MSD-first with one digit per clock using acc = acc*10 + digit.
- Returns the binary result with a validity/error flag over a second valid/ready handshake.
- Sits between a BCD source (keypad/display front-end) and binary arithmetic datapaths.

Parameters:
- DIGITS, 4, number of BCD digits in the input word; legal range ≥1.
- BIN_W, 14, output width.
  - Must be ≥ ceil(log2(10^DIGITS)).
  - The default covers 9999.
  - Values below the minimum are illegal and flagged at elaboration.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_bcd is valid.
- in_ready  output  1  block can accept a word.
- in_bcd  input  4*DIGITS  packed BCD; digit DIGITS-1 (MSD) in the top nibble.
- out_valid  output  1  out_bin/out_err are valid.
- out_ready  input  1  consumer accepts the result.
- out_bin  output  BIN_W  binary value.
- out_err  output  1  at least one nibble was >9.

Behaviour:
- One clock; reset is synchronous and active-high. rst is sampled on the rising clk edge only.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, out_bin=0, out_err=0.
  - Internal acc, shift register and digit counter all 0.
- States:
  - IDLE:
    - in_ready=1.
    - On in_valid&in_ready: latch in_bcd into the shift register, acc←0, err←0, cnt←DIGITS-1, go to CONV.
  - CONV:
    - in_ready=0.
    - Each cycle: d = top nibble of the shift register.
    - If d>9, err←1.
    - acc←(acc<<3)+(acc<<1)+d, computed at BIN_W width. Intermediates never exceed the final value, so there is no overflow for legal digits.
    - Shift register shifts left by 4.
    - If cnt==0, go to DONE; else cnt←cnt-1.
  - DONE:
    - out_valid=1.
    - out_bin = err ? 0 : acc.
    - out_err = err.
    - Outputs are held stable while out_ready=0.
    - On out_ready: out_valid←0, go to IDLE.
- Latency: accept at edge k; out_valid is first high after edge k+DIGITS.
- Throughput: one word per DIGITS+2 cycles minimum. in_ready is high only in IDLE; there is no overlap.
- Invalid digits:
  - Conversion still runs its full DIGITS cycles.
  - out_err=1 and out_bin=0.
  - No early exit.
- in_valid while not in IDLE is ignored. in_bcd need only be stable at the accepting edge.
- out_ready while out_valid=0 has no effect.
- rst in any state, including mid-CONV or DONE with a pending result:
  - Returns to reset values on that edge.
  - The result is discarded; no out_valid pulse follows.
- DIGITS=1: CONV lasts exactly one cycle; behaviour is identical to the 4-bit combinational block plus a 1-cycle register stage.

Decomposition:
- Shared package bcd_pkg:
  - State encoding localparams ST_IDLE=2'd0, ST_CONV=2'd1, ST_DONE=2'd2.
  - BCD_MAX_DIGIT=4'd9.
- One natural sub-module, bcd_mac10:
  - Combinational, parametrised by BIN_W.
  - Inputs: acc, d (4-bit).
  - Outputs: acc*10+d via shift-add, plus digit_bad=(d>9).
  - Instantiated once in the CONV datapath.

Test Plan:
- Reset, then in_bcd=16'h1234 with in_valid=1 for one cycle:
  - out_valid rises exactly 4 cycles after the accept edge.
  - out_bin=14'd1234 (0x4D2), out_err=0.
- Boundaries: in_bcd=16'h0000 → out_bin=0; in_bcd=16'h9999 → out_bin=9999 (0x270F). Both with out_err=0.
- Invalid digit: in_bcd=16'h12A4 → after 4 cycles out_valid=1, out_err=1, out_bin=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid with in_bcd=16'h0042.
  - out_bin=42 and out_valid are stable throughout.
  - in_ready stays 0.
  - Pulse out_ready → next cycle out_valid=0, in_ready=1.
- Reset mid-operation: assert rst on the 2nd CONV cycle of 16'h5678.
  - Next cycle in_ready=1, out_valid=0.
  - No result appears.
  - A following 16'h0007 yields out_bin=7.
- Back-to-back stream 16'h0001, 16'h0010, 16'h0100, 16'h1000 with out_ready tied high:
  - Outputs are 1, 10, 100, 1000 in order.
  - Accepts are spaced exactly 6 cycles apart.
  - With DIGITS=2, BIN_W=7, input 8'h99 → 99.
